// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Shares the single external line-memory port between the instruction cache
// and the data cache. One request is granted at a time. Exactly one memory
// transaction is outstanding, and its response is routed back to the cache
// that owns it.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin tie-break (loser of the last grant wins)
//                  undefined -> fixed priority, the D-cache wins ties
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   i_req/i_addr        I-cache line read request (held until i_gnt)
//   i_gnt               one-cycle grant pulse to the I-cache
//   i_rvalid/i_rdata    one-cycle read response to the I-cache
//   d_req/d_we/d_addr/d_wdata
//                       D-cache line read/write request (held until d_gnt)
//   d_gnt               one-cycle grant pulse to the D-cache
//   d_rvalid/d_rdata    one-cycle read data / write ack to the D-cache
//   mem_req/mem_we/mem_addr/mem_wdata
//                       memory request, held stable until mem_ready
//   mem_ready           memory accepts the request this cycle
//   mem_rvalid/mem_rdata
//                       memory response (read data or write ack)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [LINE_BYTES*8-1:0] i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [LINE_BYTES*8-1:0] d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [LINE_BYTES*8-1:0] d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [LINE_BYTES*8-1:0] mem_rdata
);

    localparam int DW = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    owner_t                  lastOwner_q, lastOwner_d;
    logic [ADDR_WIDTH-1:0]   reqAddr_q, reqAddr_d;
    logic                    reqWe_q, reqWe_d;
    logic [DW-1:0]           reqWdata_q, reqWdata_d;

    logic                    anyReq;
    owner_t                  winner;

    // Winner selection. A lone requester always wins; only a tie depends on
    // the build option.
    always_comb begin
        anyReq = i_req | d_req;
        winner = OWN_I;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            winner = (lastOwner_q == OWN_I) ? OWN_D : OWN_I;
`else
            winner = OWN_D;
`endif
        end else if (d_req) begin
            winner = OWN_D;
        end
    end

    // Next-state and handshake outputs. Grants and response pulses are
    // suppressed while rst is high, so a reset cycle never hands out a grant
    // that the registers are about to discard.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        reqAddr_d   = reqAddr_q;
        reqWe_d     = reqWe_q;
        reqWdata_d  = reqWdata_q;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        i_rvalid    = 1'b0;
        d_rvalid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (anyReq && !rst) begin
                    owner_d     = winner;
                    lastOwner_d = winner;
                    state_d     = S_ISSUE;
                    if (winner == OWN_D) begin
                        d_gnt      = 1'b1;
                        reqAddr_d  = d_addr;
                        reqWe_d    = d_we;
                        reqWdata_d = d_wdata;
                    end else begin
                        i_gnt      = 1'b1;
                        reqAddr_d  = i_addr;
                        reqWe_d    = 1'b0;
                        reqWdata_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid && !rst) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid = 1'b1;
                    end else begin
                        i_rvalid = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-request registers. Reset abandons any outstanding
    // transaction; last owner resets to D so the I-cache wins the first
    // round-robin tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            lastOwner_q <= OWN_D;
            reqAddr_q   <= '0;
            reqWe_q     <= 1'b0;
            reqWdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            reqAddr_q   <= reqAddr_d;
            reqWe_q     <= reqWe_d;
            reqWdata_q  <= reqWdata_d;
        end
    end

    // The captured fields drive the memory port directly, so they stay
    // stable for however long mem_ready stalls the issue phase.
    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = mem_req & reqWe_q;
    assign mem_addr  = reqAddr_q;
    assign mem_wdata = reqWdata_q;

    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
